cache_rplc_policy: RTL and testbench
====================================

// Module: cache_rplc_policy
// PURPOSE
//  Multi-mode victim-selection unit for the L0 cache; successor to the fixed round-robin line counter.
//  Tracks per-line valid bits and always presents a registered victim index.
//  Invalid lines are filled first. Once all lines are valid, the victim follows the mode:
//  FIFO, tree-PLRU or LFSR-random.
//  Policy state is updated the cycle after a fill, hit, invalidate, flush or mode change.
// PARAMETERS
//  LOG2_NUM_BLKS  3        log2 of line count; NUM_BLKS = 2**LOG2_NUM_BLKS; legal range 1..6
//  LFSR_SEED      16'hACE1 reset value of the 16-bit random LFSR; must be non-zero
// PORTS
//  clk              in   1              clock
//  rst_n            in   1              asynchronous, active-low reset
//  mode_i           in   2              0=FIFO 1=tree-PLRU 2=random 3=reserved (behaves as FIFO)
//  flush_i          in   1              invalidate all lines and reset policy state
//  inv_i            in   1              invalidate line inv_idx_i
//  inv_idx_i        in   LOG2_NUM_BLKS  line to invalidate
//  alloc_i          in   1              miss fill: consume rplc_line_idx_o (sampled only when ready_o=1)
//  hit_i            in   1              hit on line hit_idx_i (PLRU touch)
//  hit_idx_i        in   LOG2_NUM_BLKS  line that hit
//  ready_o          out  1              rplc_line_idx_o is up to date
//  rplc_line_idx_o  out  LOG2_NUM_BLKS  next victim line
//  valid_vec_o      out  NUM_BLKS       per-line valid bits
//  all_valid_o      out  1              &valid_vec_o
// BEHAVIOUR
//  Reset values:
//   - valid=0, rr_q=0, plru_q=0 (NUM_BLKS-1 bits), lfsr_q=LFSR_SEED, mode_q=0
//   - rplc_line_idx_o=0, ready_o=1, all_valid_o=0
//  Victim selection (combinational from state, registered into rplc_line_idx_o):
//   - If any line is invalid: the victim is the lowest-indexed invalid line, in every mode.
//   - Otherwise, by mode:
//     - FIFO: rr_q.
//     - PLRU: walk the tree from root node 0. Node n has children 2n+1 / 2n+2.
//       Bit 0 selects the left (lower-index) half.
//     - Random: lfsr_q[LOG2_NUM_BLKS-1:0].
//  LFSR:
//   - Galois, x^16+x^14+x^13+x^11+1.
//   - Free-running: advances every clock, including when idle.
//  Accepted alloc (alloc_i & ready_o), victim v:
//   - valid[v]<=1
//   - rr_q<=v+1, modulo NUM_BLKS wrap
//   - PLRU touch v: every node on v's path is set to point away from v
//  Hit:
//   - PLRU touch hit_idx_i; valid/rr unchanged.
//   - Hit on an invalid line is ignored.
//  Inv: valid[inv_idx_i]<=0; policy state is kept.
//  Flush:
//   - valid<=0, rr_q<=0, plru_q<=0; lfsr keeps running.
//   - Overrides every other input in the same cycle.
//  Mode change (mode_i != mode_q):
//   - mode_q<=mode_i, rr_q<=0, plru_q<=0
//   - valid bits are kept
//  Simultaneous events:
//   - alloc+hit: alloc touch applied, hit touch dropped.
//   - alloc+inv, same line: line ends invalid (inv wins).
//   - alloc+inv, different lines: both applied.
//  Latency and ready_o:
//   - Any state update in cycle N (alloc/hit/inv/flush/mode change) drives ready_o=0 in cycle N+1.
//   - rplc_line_idx_o is updated at the end of N+1; ready_o=1 again in N+2 unless another update occurs.
//   - With no updates, rplc_line_idx_o tracks the victim with 1-cycle latency.
//     In random mode it therefore changes every cycle while ready_o=1.
//   - alloc_i while ready_o=0 is ignored: no state change.
//  Async reset mid-operation: all state returns to reset values immediately.
//  A fill in progress is lost; the cache must refill.
// TESTING
//  T1 (reset, any mode): 8 allocs, each after ready_o=1 -> victims 0..7; all_valid_o=1; rr_q=0.
//  T2 (FIFO, full): 10 allocs -> victims 0,1,..,7,0,1; ready_o low exactly 1 cycle after each alloc.
//  T3 (PLRU, full, LOG2=2): hits on 0,1,2,3 -> victim 0; hit 0 -> victim 2; hit 2 -> victim 1.
//  T4 (full): inv line 5 -> victim 5 after 1 cycle; alloc -> line 5 valid; next victim back to policy choice.
//  T5 (same cycle): alloc(victim 3)+inv 3 -> valid[3]=0.
//  T5 (same cycle): flush+alloc -> valid_vec_o=0, victim 0.
//  T5 (same cycle): mode 0->1 -> plru_q=0, valid kept.
//  T6 (random, full): victim sequence matches the LFSR reference model from LFSR_SEED.
//  T6 (reset mid-fill): rst_n low mid-fill -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/cache_rplc_policy_if.sv
// Bus between the L0 cache controller (master) and its victim-selection unit (slave).
// Handshake: alloc_i is a request that is consumed only in a cycle where ready_o=1,
// and the index consumed is the rplc_line_idx_o presented in that same cycle;
// alloc_i while ready_o=0 is dropped. All other request inputs are sampled every cycle.
interface cache_rplc_policy_if #(
  parameter int LOG2_NUM_BLKS = 3
);
  localparam int NUM_BLKS = 1 << LOG2_NUM_BLKS;

  logic [1:0]               mode_i;
  logic                     flush_i;
  logic                     inv_i;
  logic [LOG2_NUM_BLKS-1:0] inv_idx_i;
  logic                     alloc_i;
  logic                     hit_i;
  logic [LOG2_NUM_BLKS-1:0] hit_idx_i;
  logic                     ready_o;
  logic [LOG2_NUM_BLKS-1:0] rplc_line_idx_o;
  logic [NUM_BLKS-1:0]      valid_vec_o;
  logic                     all_valid_o;

  modport master (
    output mode_i, flush_i, inv_i, inv_idx_i, alloc_i, hit_i, hit_idx_i,
    input  ready_o, rplc_line_idx_o, valid_vec_o, all_valid_o
  );

  modport slave (
    input  mode_i, flush_i, inv_i, inv_idx_i, alloc_i, hit_i, hit_idx_i,
    output ready_o, rplc_line_idx_o, valid_vec_o, all_valid_o
  );
endinterface

// File: rtl/cache_rplc_policy.sv
// Victim-selection unit for the L0 cache: fills invalid lines first, then picks a
// victim by FIFO, tree-PLRU or LFSR-random policy; the victim index is registered.
module cache_rplc_policy #(
  parameter int          LOG2_NUM_BLKS = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_rplc_policy_if.slave bus
);
  localparam int NUM_BLKS = 1 << LOG2_NUM_BLKS;
  localparam int NODES    = NUM_BLKS - 1;

  typedef logic [LOG2_NUM_BLKS-1:0] idx_t;

  logic [NUM_BLKS-1:0] valid_q, valid_d;
  idx_t                rr_q, rr_d;
  logic [NODES-1:0]    plru_q, plru_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [1:0]          mode_q, mode_d;
  idx_t                rplc_q;
  logic                ready_q;

  idx_t victim_c;
  idx_t first_inv;
  logic any_inv;
  logic alloc_acc, hit_ok, mode_chg, update;

  // Point every node on the path to 'line' away from it.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                  input idx_t line);
    logic [NODES-1:0] r;
    int node;
    r    = tree;
    node = 0;
    for (int l = 0; l < LOG2_NUM_BLKS; l++) begin
      for (int n = 0; n < NODES; n++) begin
        if (n == node) r[n] = ~line[LOG2_NUM_BLKS-1-l];
      end
      node = 2 * node + 1 + (line[LOG2_NUM_BLKS-1-l] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic idx_t plru_victim(input logic [NODES-1:0] tree);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < LOG2_NUM_BLKS; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) begin
        if (n == node) b = tree[n];
      end
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return idx_t'(node - NODES);
  endfunction

  always_comb begin
    any_inv   = 1'b0;
    first_inv = '0;
    for (int i = NUM_BLKS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_inv   = 1'b1;
        first_inv = idx_t'(i);
      end
    end
  end

  always_comb begin
    victim_c = rr_q;
    if (any_inv) begin
      victim_c = first_inv;
    end else begin
      case (mode_q)
        2'd1:    victim_c = plru_victim(plru_q);
        2'd2:    victim_c = lfsr_q[LOG2_NUM_BLKS-1:0];
        default: victim_c = rr_q;
      endcase
    end
  end

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign alloc_acc = bus.alloc_i & ready_q;
  assign hit_ok    = bus.hit_i & valid_q[bus.hit_idx_i];
  assign mode_chg  = bus.mode_i != mode_q;
  assign update    = bus.flush_i | alloc_acc | hit_ok | bus.inv_i | mode_chg;

  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    plru_d  = plru_q;
    mode_d  = mode_q;
    if (bus.flush_i) begin
      valid_d = '0;
      rr_d    = '0;
      plru_d  = '0;
    end else begin
      // The consumed victim is the registered index the cache saw, not victim_c.
      if (alloc_acc) begin
        valid_d[rplc_q] = 1'b1;
        rr_d            = rplc_q + idx_t'(1);
        plru_d          = plru_touch(plru_q, rplc_q);
      end else if (hit_ok) begin
        plru_d = plru_touch(plru_q, bus.hit_idx_i);
      end
      if (bus.inv_i) valid_d[bus.inv_idx_i] = 1'b0;
      if (mode_chg) begin
        mode_d = bus.mode_i;
        rr_d   = '0;
        plru_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      plru_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= 2'd0;
      rplc_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      plru_q  <= plru_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      rplc_q  <= victim_c;
      ready_q <= ~update;
    end
  end

  assign bus.ready_o         = ready_q;
  assign bus.rplc_line_idx_o = rplc_q;
  assign bus.valid_vec_o     = valid_q;
  assign bus.all_valid_o     = &valid_q;
endmodule

// File: tb/tb_cache_rplc_policy.sv
// Scoreboard bench for cache_rplc_policy: an 8-line instance for fill/FIFO/PLRU/random/reset
// sequences and a 4-line instance for the PLRU tree walk.
module tb_cache_rplc_policy;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cache_rplc_policy_if #(.LOG2_NUM_BLKS(3)) bus_a ();
  cache_rplc_policy_if #(.LOG2_NUM_BLKS(2)) bus_b ();

  cache_rplc_policy #(.LOG2_NUM_BLKS(3), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  cache_rplc_policy #(.LOG2_NUM_BLKS(2), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Expected {victim, valid_vec} after each update, popped when ready_o returns high.
  logic [10:0] exp_a_q[$];
  logic [5:0]  exp_b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference LFSR, free-running from the seed since the last reset.
  logic [15:0] lfsr_m, lfsr_prev;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = ~n[15];
      n[13] = ~n[13];
      n[12] = ~n[12];
      n[10] = ~n[10];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_step(lfsr_m);
    end
  end

  // Monitors
  logic        prev_a = 1'b1, prev_b = 1'b1;
  int          low_a = 0, low_b = 0;
  logic [10:0] ea;
  logic [5:0]  eb;

  always @(negedge clk) begin
    if (bus_a.ready_o === 1'b0) begin
      low_a++;
    end else if (prev_a === 1'b0) begin
      if (exp_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: ready rose with no expected entry at %0t", $time);
      end else begin
        ea = exp_a_q.pop_front();
        chk("a_victim", 32'(bus_a.rplc_line_idx_o), 32'(ea[10:8]));
        chk("a_valid", 32'(bus_a.valid_vec_o), 32'(ea[7:0]));
        chk("a_all_valid", 32'(bus_a.all_valid_o), 32'(&ea[7:0]));
        chk("a_ready_low_cycles", 32'(low_a), 32'd1);
      end
      low_a = 0;
    end
    prev_a = bus_a.ready_o;
  end

  always @(negedge clk) begin
    if (bus_b.ready_o === 1'b0) begin
      low_b++;
    end else if (prev_b === 1'b0) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: ready rose with no expected entry at %0t", $time);
      end else begin
        eb = exp_b_q.pop_front();
        chk("b_victim", 32'(bus_b.rplc_line_idx_o), 32'(eb[5:4]));
        chk("b_valid", 32'(bus_b.valid_vec_o), 32'(eb[3:0]));
        chk("b_ready_low_cycles", 32'(low_b), 32'd1);
      end
      low_b = 0;
    end
    prev_b = bus_b.ready_o;
  end

  // Drivers
  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (bus_a.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL a_ready_timeout: ready=%b required 1", bus_a.ready_o);
    end
  endtask

  task automatic wait_ready_b();
    int n = 0;
    @(negedge clk);
    while (bus_b.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus_b.ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL b_ready_timeout: ready=%b required 1", bus_b.ready_o);
    end
  endtask

  task automatic step_a(input logic a, input logic h, input logic iv, input logic fl,
                        input logic [1:0] md, input logic [2:0] hidx, input logic [2:0] iidx,
                        input bit rnd, input logic [2:0] ev, input logic [7:0] evv);
    wait_ready_a();
    bus_a.alloc_i   = a;
    bus_a.hit_i     = h;
    bus_a.inv_i     = iv;
    bus_a.flush_i   = fl;
    bus_a.mode_i    = md;
    bus_a.hit_idx_i = hidx;
    bus_a.inv_idx_i = iidx;
    @(negedge clk);
    bus_a.alloc_i = 1'b0;
    bus_a.hit_i   = 1'b0;
    bus_a.inv_i   = 1'b0;
    bus_a.flush_i = 1'b0;
    if (rnd) begin
      // Victim latched at the end of the ready-low cycle comes from the LFSR value of that cycle.
      @(posedge clk);
      #1;
      exp_a_q.push_back({lfsr_prev[2:0], evv});
    end else begin
      exp_a_q.push_back({ev, evv});
    end
  endtask

  task automatic step_b(input logic a, input logic h, input logic [1:0] md,
                        input logic [1:0] hidx, input logic [1:0] ev, input logic [3:0] evv);
    wait_ready_b();
    bus_b.alloc_i   = a;
    bus_b.hit_i     = h;
    bus_b.mode_i    = md;
    bus_b.hit_idx_i = hidx;
    @(negedge clk);
    bus_b.alloc_i = 1'b0;
    bus_b.hit_i   = 1'b0;
    exp_b_q.push_back({ev, evv});
  endtask

  logic [1:0] hits_b[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
  logic [1:0] vict_b[6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};

  initial begin
    rst_n = 1'b0;
    bus_a.mode_i = 2'd0; bus_a.flush_i = 1'b0; bus_a.inv_i = 1'b0; bus_a.inv_idx_i = '0;
    bus_a.alloc_i = 1'b0; bus_a.hit_i = 1'b0; bus_a.hit_idx_i = '0;
    bus_b.mode_i = 2'd0; bus_b.flush_i = 1'b0; bus_b.inv_i = 1'b0; bus_b.inv_idx_i = '0;
    bus_b.alloc_i = 1'b0; bus_b.hit_i = 1'b0; bus_b.hit_idx_i = '0;
    #23 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_ready", 32'(bus_a.ready_o), 32'd1);
    chk("reset_victim", 32'(bus_a.rplc_line_idx_o), 32'd0);
    chk("reset_valid", 32'(bus_a.valid_vec_o), 32'd0);
    chk("reset_all_valid", 32'(bus_a.all_valid_o), 32'd0);
    chk("reset_b_victim", 32'(bus_b.rplc_line_idx_o), 32'd0);

    // 4-line PLRU tree walk
    step_b(0, 0, 2'd1, 2'd0, 2'd0, 4'b0000);
    step_b(1, 0, 2'd1, 2'd0, 2'd1, 4'b0001);
    step_b(1, 0, 2'd1, 2'd0, 2'd2, 4'b0011);
    step_b(1, 0, 2'd1, 2'd0, 2'd3, 4'b0111);
    step_b(1, 0, 2'd1, 2'd0, 2'd0, 4'b1111);
    for (int k = 0; k < 6; k++) step_b(0, 1, 2'd1, hits_b[k], vict_b[k], 4'b1111);
    step_b(0, 0, 2'd0, 2'd0, 2'd0, 4'b1111);

    // Fill from empty, then FIFO wrap-around
    for (int k = 0; k < 8; k++)
      step_a(1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'((k + 1) % 8), 8'((9'd1 << (k + 1)) - 9'd1));
    for (int k = 0; k < 10; k++)
      step_a(1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'((k + 1) % 8), 8'hFF);

    // Invalidate refills first, then policy resumes at rr=6
    step_a(0, 0, 1, 0, 2'd0, 3'd0, 3'd5, 0, 3'd5, 8'hDF);
    step_a(1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'd6, 8'hFF);

    // Same-cycle alloc + inv on the victim line, then flush + alloc
    step_a(0, 0, 1, 0, 2'd0, 3'd0, 3'd3, 0, 3'd3, 8'hF7);
    step_a(1, 0, 1, 0, 2'd0, 3'd0, 3'd3, 0, 3'd3, 8'hF7);
    step_a(1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 0, 3'd0, 8'h00);
    for (int k = 0; k < 8; k++)
      step_a(1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'((k + 1) % 8), 8'((9'd1 << (k + 1)) - 9'd1));

    // Hit in FIFO mode still touches the tree; the mode change must clear it
    step_a(0, 1, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'd0, 8'hFF);
    step_a(0, 0, 0, 0, 2'd1, 3'd0, 3'd0, 0, 3'd0, 8'hFF);
    step_a(0, 1, 0, 0, 2'd1, 3'd0, 3'd0, 0, 3'd4, 8'hFF);

    // Random mode against the reference LFSR, with idle gaps
    step_a(0, 0, 0, 0, 2'd2, 3'd0, 3'd0, 1, 3'd0, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      step_a(0, 1, 0, 0, 2'd2, 3'($urandom_range(0, 7)), 3'd0, 1, 3'd0, 8'hFF);
    end

    // Reset in the middle of a fill
    step_a(0, 0, 0, 1, 2'd2, 3'd0, 3'd0, 0, 3'd0, 8'h00);
    wait_ready_a();
    bus_a.alloc_i = 1'b1;
    @(negedge clk);
    bus_a.alloc_i = 1'b0;
    exp_a_q.push_back({3'd0, 8'h00});
    #2 rst_n = 1'b0;
    bus_a.mode_i = 2'd0;
    #1;
    chk("midfill_reset_ready", 32'(bus_a.ready_o), 32'd1);
    chk("midfill_reset_victim", 32'(bus_a.rplc_line_idx_o), 32'd0);
    chk("midfill_reset_valid", 32'(bus_a.valid_vec_o), 32'd0);
    chk("midfill_reset_all_valid", 32'(bus_a.all_valid_o), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step_a(1, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 3'd1, 8'h01);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
